// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter (optional PS2_TX_RETRY_EN: one automatic retry)
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int FILTER_LEN     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    output logic       busy,
    output logic       rx_inhibit,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);
    localparam int TMAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int TW   = $clog2(TMAX);
    localparam int FW   = $clog2(FILTER_LEN) + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_START, S_DATA, S_ACK, S_WAIT_IDLE, S_DONE, S_ERR
    } state_t;

    state_t          state, state_next;
    logic [TW-1:0]   timer;
    logic [3:0]      bitcnt;
    logic [7:0]      data_q;
    logic            parity_q;
    logic            data_oe_q;
    logic            clk_s1, clk_s2, data_s1, data_s2;
    logic            clk_f, clk_f_d;
    logic [FW-1:0]   fcnt;
    logic            fall, timeout, fail, adv, timer_clr;
`ifdef PS2_TX_RETRY_EN
    logic            retry_q;
`endif

    // Synchronizers plus a debounce on the clock; data only needs the synchronizer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            data_s1 <= 1'b1;
            data_s2 <= 1'b1;
            clk_f   <= 1'b1;
            clk_f_d <= 1'b1;
            fcnt    <= '0;
        end else begin
            clk_s1  <= ps2_clk_in;
            clk_s2  <= clk_s1;
            data_s1 <= ps2_data_in;
            data_s2 <= data_s1;
            clk_f_d <= clk_f;
            if (clk_s2 == clk_f) begin
                fcnt <= '0;
            end else if (fcnt == FW'(FILTER_LEN - 1)) begin
                clk_f <= clk_s2;
                fcnt  <= '0;
            end else begin
                fcnt <= fcnt + FW'(1);
            end
        end
    end

    assign fall    = clk_f_d & ~clk_f;
    assign timeout = (timer == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_next  = state;
        tx_ready    = 1'b0;
        tx_done     = 1'b0;
        tx_error    = 1'b0;
        ps2_clk_oe  = 1'b0;
        ps2_data_oe = 1'b0;
        fail        = 1'b0;
        adv         = 1'b0;
        case (state)
            S_IDLE: begin
                tx_ready = 1'b1;
                if (tx_valid) state_next = S_INHIBIT;
            end
            S_INHIBIT: begin
                ps2_clk_oe = 1'b1;
                if (timer == TW'(INHIBIT_CYCLES - 1)) begin
                    ps2_data_oe = 1'b1;
                    state_next  = S_START;
                end
            end
            S_START: begin
                ps2_data_oe = 1'b1;
                if (timeout) fail = 1'b1;
                else if (fall) begin
                    adv        = 1'b1;
                    state_next = S_DATA;
                end
            end
            S_DATA: begin
                ps2_data_oe = data_oe_q;
                if (timeout) fail = 1'b1;
                else if (fall) begin
                    adv = 1'b1;
                    if (bitcnt == 4'd9) state_next = S_ACK;
                end
            end
            S_ACK: begin
                if (timeout) fail = 1'b1;
                else if (fall) begin
                    if (data_s2) fail = 1'b1;
                    else         state_next = S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                if (timeout) fail = 1'b1;
                else if (clk_f && data_s2) state_next = S_DONE;
            end
            S_DONE: begin
                tx_done    = 1'b1;
                state_next = S_IDLE;
            end
            S_ERR: begin
                tx_error   = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
        if (fail) begin
`ifdef PS2_TX_RETRY_EN
            state_next = retry_q ? S_ERR : S_INHIBIT;
`else
            state_next = S_ERR;
`endif
        end
    end

    assign busy       = (state != S_IDLE);
    assign rx_inhibit = busy;
    // The timer restarts on entry to INHIBIT and START, then runs through the whole frame.
    assign timer_clr  = (state_next == S_IDLE) ||
                        ((state_next != state) && (state_next == S_INHIBIT || state_next == S_START));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            timer     <= '0;
            bitcnt    <= '0;
            data_q    <= '0;
            parity_q  <= 1'b0;
            data_oe_q <= 1'b0;
`ifdef PS2_TX_RETRY_EN
            retry_q   <= 1'b0;
`endif
        end else begin
            state <= state_next;
            timer <= timer_clr ? '0 : timer + TW'(1);
            if (state == S_IDLE && tx_valid) begin
                data_q   <= tx_data;
                parity_q <= ~^tx_data;
`ifdef PS2_TX_RETRY_EN
                retry_q  <= 1'b0;
`endif
            end
`ifdef PS2_TX_RETRY_EN
            if (fail) retry_q <= 1'b1;
`endif
            if (state == S_START && adv) begin
                data_oe_q <= ~data_q[0];
                bitcnt    <= 4'd1;
            end
            if (state == S_DATA && adv) begin
                bitcnt <= bitcnt + 4'd1;
                case (bitcnt)
                    4'd8:    data_oe_q <= ~parity_q;
                    4'd9:    data_oe_q <= 1'b0;
                    default: data_oe_q <= ~data_q[bitcnt[2:0]];
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - scoreboard bench for ps2_host_tx with a clocking PS/2 device model
module tb_ps2_host_tx;
    localparam int INH = 200;
    localparam int TMO = 3000;
    localparam int H   = 25;
`ifdef PS2_TX_RETRY_EN
    localparam int NTRY = 2;
`else
    localparam int NTRY = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_done, tx_error, busy, rx_inhibit;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       ps2_clk_line, ps2_data_line;

    assign ps2_clk_line  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_line = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .FILTER_LEN(4)) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_done(tx_done), .tx_error(tx_error), .busy(busy), .rx_inhibit(rx_inhibit),
        .ps2_clk_in(ps2_clk_line), .ps2_data_in(ps2_data_line),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] frame;
        int          kind;   // 0 ack, 1 nack, 2 timeout
    } exp_t;
    exp_t exp_q[$];

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    int          inh_run = 0;
    int          last_inh = 0;
    int          inh_cnt = 0;
    int          pulse_cnt = 0;
    logic        clk_oe_prev = 1'b0;
    logic        pulse_prev = 1'b0;
    logic [10:0] cap_frame = '0;
    logic        dev_stop_seen = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] d);
        return {1'b1, ~^d, d, 1'b0};
    endfunction

    // Output monitor: pops the scoreboard on each done/error pulse.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        check_eq("rx_inhibit_eq_busy", rx_inhibit, busy);
        check_eq("done_err_exclusive", tx_done & tx_error, 1'b0);
        if (ps2_clk_oe) inh_run++;
        if (clk_oe_prev && !ps2_clk_oe) begin
            start_cyc = cyc;
            inh_cnt++;
            last_inh = inh_run;
            inh_run = 0;
        end
        if (pulse_prev) begin
            check_eq("post_busy", busy, 1'b0);
            check_eq("post_ready", tx_ready, 1'b1);
            check_eq("post_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
        end
        if (tx_done || tx_error) begin
            pulse_cnt++;
            if (exp_q.size() == 0) begin
                check_eq("unexpected_pulse", 1'b1, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check_eq("outcome_is_error", tx_error, (e.kind != 0));
                if (e.kind == 2) check_eq("timeout_latency", cyc - start_cyc, TMO);
                else             check_eq("device_frame", cap_frame, e.frame);
            end
        end
        pulse_prev  = tx_done | tx_error;
        clk_oe_prev = ps2_clk_oe;
    end

    // Device model: waits for request-to-send, clocks 10 bits in, then ACKs or NACKs.
    task automatic dev_receive(input bit nack, input int abort_at);
        int n;
        cap_frame = '0;
        n = 0;
        while (!ps2_clk_oe && n < 4 * INH) begin tick(1); n++; end
        n = 0;
        while (ps2_clk_oe && n < 4 * INH) begin tick(1); n++; end
        cap_frame[0] = ps2_data_line;
        tick(20);
        for (int i = 0; i < 10; i++) begin
            dev_clk_low = 1'b1;
            tick(H);
            if (i == abort_at) begin
                rst = 1'b0;
                tick(1);
                check_eq("abort_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
                check_eq("abort_ready", tx_ready, 1'b1);
                check_eq("abort_pulses", {tx_done, tx_error}, 2'b00);
                rst = 1'b1;
                dev_clk_low = 1'b0;
                tick(H);
                dev_stop_seen = 1'b1;
                return;
            end
            dev_clk_low = 1'b0;
            tick(H);
            cap_frame[i+1] = ps2_data_line;
        end
        dev_stop_seen = 1'b1;
        dev_data_low = !nack;
        dev_clk_low = 1'b1;
        tick(H);
        dev_clk_low = 1'b0;
        tick(H);
        dev_data_low = 1'b0;
    endtask

    task automatic wait_outcome();
        int n = 0;
        while (exp_q.size() != 0 && n < 20000) begin tick(1); n++; end
        check_eq("outcome_seen", exp_q.size(), 0);
        exp_q.delete();
        tick(5);
    endtask

    task automatic send(input logic [7:0] d, input int kind, input int ndev);
        exp_q.push_back('{frame: mk_frame(d), kind: kind});
        tx_data  = d;
        tx_valid = 1'b1;
        tick(1);
        check_eq("accept_latency_clk_oe", ps2_clk_oe, 1'b1);
        tx_valid = 1'b0;
        for (int k = 0; k < ndev; k++) dev_receive(kind == 1, -1);
        wait_outcome();
    endtask

    initial begin
        int inh0, pc;
        tick(3);
        check_eq("rst_ready", tx_ready, 1'b1);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_inhibit", rx_inhibit, 1'b0);
        check_eq("rst_pulses", {tx_done, tx_error}, 2'b00);
        check_eq("rst_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
        rst = 1'b1;
        tick(20);

        send(8'hED, 0, 1);
        check_eq("inhibit_len", last_inh, INH);
        send(8'h01, 0, 1);
        send(8'hFF, 0, 1);
        send(8'hF4, 1, NTRY);

        inh0 = inh_cnt;
        send(8'h55, 2, 0);
        check_eq("timeout_inhibits", inh_cnt - inh0, NTRY);
        check_eq("timeout_inhibit_len", last_inh, INH);

        tx_data  = 8'hED;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        pc = pulse_cnt;
        dev_receive(1'b0, 3);
        tick(100);
        check_eq("abort_no_pulse", pulse_cnt, pc);
        send(8'hED, 0, 1);

        exp_q.push_back('{frame: mk_frame(8'h3C), kind: 0});
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        tick(1);
        check_eq("hold_accept", ps2_clk_oe, 1'b1);
        dev_stop_seen = 1'b0;
        fork
            dev_receive(1'b0, -1);
            begin
                while (!dev_stop_seen) begin
                    tx_data = 8'($urandom);
                    tick(1);
                end
                tx_valid = 1'b0;
            end
        join
        wait_outcome();
        check_eq("final_idle", tx_ready, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
